// File: rtl/wait_event_ctrl.sv
// Multi-channel wait-event controller: arms on a command, watches one channel of the
// event bus for an edge (counted N times) or a level, bounded by an optional cycle timeout.
module wait_event_ctrl #(
    parameter int WAIT_SIZE     = 16,
    parameter int WAIT_WIDTH    = 4,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int OCC_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wait_en,
    input  logic [WAIT_WIDTH-1:0]    i_sel,
    input  logic [1:0]               i_mode,
    input  logic [OCC_WIDTH-1:0]     i_occ,
    input  logic [TIMEOUT_WIDTH-1:0] i_max_timeout,
    input  logic                     i_abort,
    input  logic [WAIT_SIZE-1:0]     i_wait,
    output logic                     o_busy,
    output logic                     o_wait_done,
    output logic                     o_timeout,
    output logic                     o_error,
    output logic [TIMEOUT_WIDTH-1:0] o_elapsed
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [WAIT_WIDTH:0]    SIZE_EXT = (WAIT_WIDTH + 1)'(WAIT_SIZE);
    localparam logic [OCC_WIDTH-1:0]   OCC_ONE  = OCC_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [WAIT_SIZE-1:0]   BUS_ONE  = WAIT_SIZE'(1);

    state_t                   state_q, state_d;
    logic [WAIT_WIDTH-1:0]    sel_q, sel_d;
    logic [1:0]               mode_q, mode_d;
    logic [OCC_WIDTH-1:0]     target_q, target_d;
    logic [OCC_WIDTH-1:0]     occ_q, occ_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic [WAIT_SIZE-1:0]     wait_prev_q;

    logic                     sel_ok;
    logic [WAIT_SIZE-1:0]     chan_mask;
    logic                     cur_bit;
    logic                     prev_bit;
    logic                     edge_hit;
    logic                     cond_met;
    logic                     tmo_hit;
    logic [TIMEOUT_WIDTH-1:0] elapsed_inc;

    // Channel extraction by mask keeps the select width independent of the bus width.
    always_comb begin
        sel_ok      = ({1'b0, i_sel} < SIZE_EXT);
        chan_mask   = BUS_ONE << sel_q;
        cur_bit     = |(i_wait & chan_mask);
        prev_bit    = |(wait_prev_q & chan_mask);
        edge_hit    = mode_q[0] ? (~cur_bit & prev_bit) : (cur_bit & ~prev_bit);
        elapsed_inc = elapsed_q + TMO_ONE;
        tmo_hit     = (timeout_q != '0) && (elapsed_inc == timeout_q);
        if (mode_q[1]) begin
            cond_met = mode_q[0] ? ~cur_bit : cur_bit;
        end else begin
            cond_met = edge_hit && ((occ_q + OCC_ONE) == target_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mode_d    = mode_q;
        target_d  = target_q;
        occ_d     = occ_q;
        timeout_d = timeout_q;
        elapsed_d = elapsed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_wait_en) begin
                    if (sel_ok) begin
                        sel_d     = i_sel;
                        mode_d    = i_mode;
                        target_d  = (i_occ == '0) ? OCC_ONE : i_occ;
                        timeout_d = i_max_timeout;
                        occ_d     = '0;
                        elapsed_d = '0;
                        busy_d    = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    // Elapsed saturates so a disabled timeout never wraps the report.
                    if (elapsed_q != '1) begin
                        elapsed_d = elapsed_inc;
                    end
                    if (cond_met) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (!mode_q[1] && edge_hit) begin
                        occ_d = occ_q + OCC_ONE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            mode_q      <= '0;
            target_q    <= '0;
            occ_q       <= '0;
            timeout_q   <= '0;
            elapsed_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
            wait_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            occ_q       <= occ_d;
            timeout_q   <= timeout_d;
            elapsed_q   <= elapsed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            wait_prev_q <= i_wait;
        end
    end

    assign o_busy      = busy_q;
    assign o_wait_done = done_q;
    assign o_timeout   = tmo_q;
    assign o_error     = err_q;
    assign o_elapsed   = elapsed_q;

endmodule
